// File: rtl/hilo_div_unit.sv
// Multi-cycle radix-2 restoring divider feeding the HI/LO write port: remainder on hi_o, quotient on lo_o.
// Optional macro DIV_SIGNED_EN enables signed (DIV) handling; otherwise all divides are unsigned.
module hilo_div_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_i,
  input  logic             signed_i,
  input  logic             cancel_i,
  input  logic [WIDTH-1:0] dividend_i,
  input  logic [WIDTH-1:0] divisor_i,
  output logic             busy_o,
  output logic             ready_o,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_e;

  state_e           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [WIDTH-1:0] rem_q, quo_q, dvsr_q;
  logic [WIDTH-1:0] hi_q, lo_q;
  logic             ready_q;

  logic [WIDTH:0]   rem_shift, trial;
  logic [WIDTH-1:0] rem_d, quo_d, hi_d, lo_d;
  logic [WIDTH-1:0] dvd_mag, dvs_mag;

`ifdef DIV_SIGNED_EN
  logic neg_quo_q, neg_rem_q;
`else
  logic unused_signed;
  assign unused_signed = signed_i;
`endif

  // One restoring step: shift in the next dividend bit, trial-subtract, keep or restore.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    rem_shift = {rem_q, quo_q[WIDTH-1]};
    trial     = rem_shift - {1'b0, dvsr_q};
    rem_d     = trial[WIDTH] ? rem_shift[WIDTH-1:0] : trial[WIDTH-1:0];
    quo_d     = {quo_q[WIDTH-2:0], ~trial[WIDTH]};
    hi_d      = rem_d;
    lo_d      = quo_d;
    dvd_mag   = dividend_i;
    dvs_mag   = divisor_i;
`ifdef DIV_SIGNED_EN
    if (neg_rem_q) hi_d = -rem_d;
    if (neg_quo_q) lo_d = -quo_d;
    if (signed_i && dividend_i[WIDTH-1]) dvd_mag = -dividend_i;
    if (signed_i && divisor_i[WIDTH-1])  dvs_mag = -divisor_i;
`endif
  end

  // NOTE: sequential state is written with non-blocking assignments only.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      rem_q   <= '0;
      quo_q   <= '0;
      dvsr_q  <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      ready_q <= 1'b0;
`ifdef DIV_SIGNED_EN
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          ready_q <= 1'b0;
          if (start_i) begin
            if (divisor_i == '0) begin
              // Divide by zero bypasses iteration and reports raw operands.
              hi_q    <= dividend_i;
              lo_q    <= '1;
              ready_q <= 1'b1;
              state_q <= DONE;
            end else begin
              rem_q   <= '0;
              quo_q   <= dvd_mag;
              dvsr_q  <= dvs_mag;
              cnt_q   <= '0;
              state_q <= BUSY;
`ifdef DIV_SIGNED_EN
              neg_quo_q <= signed_i && (dividend_i[WIDTH-1] ^ divisor_i[WIDTH-1]);
              neg_rem_q <= signed_i && dividend_i[WIDTH-1];
`endif
            end
          end
        end
        BUSY: begin
          if (cancel_i) begin
            state_q <= IDLE;
          end else begin
            rem_q <= rem_d;
            quo_q <= quo_d;
            cnt_q <= cnt_q + CNT_W'(1);
            if (cnt_q == LAST_CNT) begin
              hi_q    <= hi_d;
              lo_q    <= lo_d;
              ready_q <= 1'b1;
              state_q <= DONE;
            end
          end
        end
        DONE: begin
          ready_q <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          ready_q <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign busy_o  = (state_q == BUSY);
  assign ready_o = ready_q;
  assign hi_o    = hi_q;
  assign lo_o    = lo_q;

endmodule

// File: doc/hilo_div_unit.md
Name: hilo_div_unit

Overview:
- Multi-cycle radix-2 restoring divider in the EX stage; the producer side of the HI/LO register's write port.
- Accepts one divide request from EX and iterates one quotient bit per cycle.
- Delivers remainder on hi_o and quotient on lo_o with a one-cycle ready_o strobe.
- The pipeline drives the HI/LO write enable from ready_o; busy_o stalls the pipeline while iterating.

Parameters:
- WIDTH, 32, operand/result width in bits; iteration count equals WIDTH.

Ports:
- clk  input  1  clock
- rst  input  1  synchronous, active-high reset
- start_i  input  1  request strobe; sampled only in IDLE
- signed_i  input  1  1 = signed divide (DIV), 0 = unsigned (DIVU); sampled with start_i
- cancel_i  input  1  abort in-flight divide (exception/flush)
- dividend_i  input  WIDTH  dividend; sampled with start_i
- divisor_i  input  WIDTH  divisor; sampled with start_i
- busy_o  output  1  high while state is BUSY
- ready_o  output  1  one-cycle strobe; hi_o/lo_o valid
- hi_o  output  WIDTH  remainder, to HI write data
- lo_o  output  WIDTH  quotient, to LO write data

Behaviour:
- Reset (rst=1 at a clk edge):
  - state IDLE; busy_o=0, ready_o=0, hi_o=0, lo_o=0.
  - Iteration counter and working registers cleared.
  - Reset mid-divide aborts with no ready_o.
- States: IDLE, BUSY, DONE. ready_o is registered and high only in DONE.
- IDLE, start_i=1 at edge E0:
  - Operands latched.
  - divisor_i != 0: go to BUSY, counter=0.
  - divisor_i == 0: go straight to DONE with lo_o=all ones, hi_o=dividend_i (raw, no sign handling). ready_o is high in the cycle after E0.
- BUSY:
  - Each edge does one shift/trial-subtract/restore step and increments the counter.
  - On the WIDTH-th BUSY edge (E0+WIDTH, i.e. E32 by default): final hi_o/lo_o registered, go to DONE.
  - ready_o is high in the cycle after E32, so total latency is 33 edges from start to the ready_o cycle.
- DONE: lasts exactly one cycle, then go to IDLE; ready_o drops.
- hi_o/lo_o:
  - Change only on entry to DONE.
  - Hold their value afterwards until the next completion or reset.
- cancel_i:
  - In BUSY at an edge: go to IDLE immediately; no ready_o; hi_o/lo_o unchanged.
  - Ignored in IDLE and DONE.
  - cancel_i and start_i together in IDLE: start wins (cancel ignored in IDLE).
- start_i outside IDLE is ignored; no queueing.
- New start is accepted in the IDLE cycle right after DONE, giving minimum 34-edge spacing.
- busy_o is deasserted in DONE, so the pipeline samples ready_o with the stall released.
- Unsigned arithmetic: WIDTH+1-bit partial remainder; quotient bits shift in LSB-first into the working quotient.

Optional Feature:
- Macro DIV_SIGNED_EN.
- Defined:
  - signed_i is honoured. Operands are converted to magnitudes at start.
  - At DONE, quotient is negated if operand signs differ; remainder takes the dividend's sign.
  - Most-negative / -1 yields lo_o=0x80000000, hi_o=0.
- Not defined:
  - signed_i is ignored; all divides are unsigned.
  - No sign/negation logic is synthesized.

Test Plan:
- Unsigned: reset, then start with 100/7, signed_i=0 -> busy_o high 32 cycles; ready_o one cycle at edge 33; hi_o=2, lo_o=14; values held after ready_o falls.
- Signed (DIV_SIGNED_EN): -7/2 -> lo_o=0xFFFFFFFD, hi_o=0xFFFFFFFF. 0x80000000/0xFFFFFFFF -> lo_o=0x80000000, hi_o=0. Without macro, -7/2 -> lo_o=0x7FFFFFFC, hi_o=1.
- Divide by zero: 0x1234/0 -> ready_o in the cycle after start, busy_o never high; hi_o=0x1234, lo_o=0xFFFFFFFF.
- Cancel: start 100/7, assert cancel_i at BUSY edge 10 -> IDLE, no ready_o, hi_o/lo_o keep prior values. Then start 9/3 -> lo_o=3, hi_o=0 after 33 edges.
- Start while busy: pulse start_i with 50/5 during BUSY of 100/7 -> ignored; result 14/2; exactly one ready_o.
- Reset mid-op: rst=1 at BUSY edge 20 -> all outputs 0, IDLE, no ready_o. A subsequent divide completes normally.
